dff_univ_reg: RTL

- Parametrised successor to the single-bit async-reset D flip-flop.
- WIDTH-bit universal register with enable-gated modes: hold, parallel load, shift, rotate, up/down count.
- Provides complementary outputs and serial/terminal-count taps for cascading.
- Used in the lab datapath as a general storage and counter element.

---
 rtl/dff_univ_pkg.sv | 27 ++
 rtl/dff_univ_next.sv | 40 ++++
 rtl/dff_univ_reg.sv | 70 +++++++
 3 files changed

// File: rtl/dff_univ_pkg.sv
// Shared mode encodings for the universal register and its next-state logic.
// Optional synchronous clear is enabled with `define DFF_UNIV_REG_SCLR_EN.
package dff_univ_pkg;

  localparam int MODE_BITS = 3;

  localparam logic [MODE_BITS-1:0] ENC_HOLD = 3'b000;
  localparam logic [MODE_BITS-1:0] ENC_LOAD = 3'b001;
  localparam logic [MODE_BITS-1:0] ENC_SHL  = 3'b010;
  localparam logic [MODE_BITS-1:0] ENC_SHR  = 3'b011;
  localparam logic [MODE_BITS-1:0] ENC_ROL  = 3'b100;
  localparam logic [MODE_BITS-1:0] ENC_ROR  = 3'b101;
  localparam logic [MODE_BITS-1:0] ENC_INC  = 3'b110;
  localparam logic [MODE_BITS-1:0] ENC_DEC  = 3'b111;

  typedef enum logic [MODE_BITS-1:0] {
    MODE_HOLD = ENC_HOLD,
    MODE_LOAD = ENC_LOAD,
    MODE_SHL  = ENC_SHL,
    MODE_SHR  = ENC_SHR,
    MODE_ROL  = ENC_ROL,
    MODE_ROR  = ENC_ROR,
    MODE_INC  = ENC_INC,
    MODE_DEC  = ENC_DEC
  } mode_e;

endpackage

// File: rtl/dff_univ_next.sv
// Combinational next-state and terminal-count logic for dff_univ_reg.
// Unaffected by DFF_UNIV_REG_SCLR_EN; the clear override lives in the top.
module dff_univ_next
  import dff_univ_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sil,
  input  logic             sir,
  output logic [WIDTH-1:0] q_next,
  output logic             tc
);

  always_comb begin
    q_next = q;
    tc     = 1'b0;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_LOAD: q_next = d;
      MODE_SHL:  q_next = {q[WIDTH-2:0], sir};
      MODE_SHR:  q_next = {sil, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      // tc flags the wrap so a cascaded stage can use tc&cp as its enable
      MODE_INC: begin
        q_next = q + WIDTH'(1);
        tc     = &q;
      end
      MODE_DEC: begin
        q_next = q - WIDTH'(1);
        tc     = ~|q;
      end
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/dff_univ_reg.sv
// WIDTH-bit universal register (hold/load/shift/rotate/count) with async reset.
// Define DFF_UNIV_REG_SCLR_EN to add the synchronous clear input sclr.
module dff_univ_reg
  import dff_univ_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             r,
  input  logic             cp,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sir,
  input  logic             sil,
`ifdef DFF_UNIV_REG_SCLR_EN
  input  logic             sclr,
`endif
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             sol,
  output logic             sor,
  output logic             tc
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_nxt;
  logic             tc_raw;
  mode_e            mode_s;

  assign mode_s = mode_e'(mode);

  dff_univ_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .q      (q_q),
    .mode   (mode_s),
    .d      (d),
    .sil    (sil),
    .sir    (sir),
    .q_next (q_nxt),
    .tc     (tc_raw)
  );

  always_comb begin
    q_d = q_q;
`ifdef DFF_UNIV_REG_SCLR_EN
    if (cp) q_d = sclr ? RST_VAL : q_nxt;
`else
    if (cp) q_d = q_nxt;
`endif
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) q_q <= RST_VAL;
    else   q_q <= q_d;
  end

  assign q   = q_q;
  assign qn  = ~q_q;
  assign sol = q_q[WIDTH-1];
  assign sor = q_q[0];
`ifdef DFF_UNIV_REG_SCLR_EN
  assign tc  = tc_raw & ~sclr;
`else
  assign tc  = tc_raw;
`endif

endmodule
